// File: rtl/fib_seq_gen.sv
// Second-order recurrence engine: X(k) = X(k-1) + X(k-2) mod 2^WIDTH, seeded
// with 0,1 or user seeds. Streams each term and reports carry-out as ovf.
module fib_seq_gen #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] din,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     seed0,
  input  logic [WIDTH-1:0]     seed1,
  input  logic                 abort,
  output logic                 busy,
  output logic [WIDTH-1:0]     dout,
  output logic                 done,
  output logic                 ovf,
  output logic                 term_valid,
  output logic [WIDTH-1:0]     term_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0] n;
    logic [WIDTH-1:0]     s0;
    logic [WIDTH-1:0]     s1;
  } req_t;

  state_t               state;
  req_t                 req;
  logic [WIDTH-1:0]     a, b;
  logic [IDX_WIDTH-1:0] cnt, n_r, cnt_inc;
  logic                 ovf_r;
  logic [WIDTH:0]       sum;

  // Mode 0 pins the seeds to the classic Fibonacci start.
  always_comb begin
    req.n  = din;
    req.s0 = mode ? seed0 : '0;
    req.s1 = mode ? seed1 : WIDTH'(1);
  end

  assign sum     = {1'b0, a} + {1'b0, b};
  assign cnt_inc = cnt + IDX_WIDTH'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
      n_r        <= '0;
      ovf_r      <= 1'b0;
      dout       <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      term_valid <= 1'b0;
      term_data  <= '0;
    end else begin
      done       <= 1'b0;
      term_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a     <= req.s0;
          b     <= req.s1;
          cnt   <= IDX_WIDTH'(1);
          n_r   <= req.n;
          ovf_r <= 1'b0;
          state <= (req.n >= IDX_WIDTH'(2)) ? CALC : DONE;
        end
        CALC: if (abort) begin
          state <= IDLE;
        end else begin
          a          <= b;
          b          <= sum[WIDTH-1:0];
          ovf_r      <= ovf_r | sum[WIDTH];
          cnt        <= cnt_inc;
          term_valid <= 1'b1;
          term_data  <= sum[WIDTH-1:0];
          if (cnt_inc == n_r) state <= DONE;
        end
        DONE: begin
          // An abort here drops the result; dout/ovf keep the last run's values.
          state <= IDLE;
          if (!abort) begin
            dout <= (n_r == '0) ? a : b;
            ovf  <= ovf_r;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
